kw11l_timer: RTL and testbench
==============================

Name: kw11l_timer

Overview:
- KW11-L compatible line-clock for the MC1201.02 processor board; sits on the CPU Wishbone bus downstream of the processor module.
- Divides the system clock into a 50 Hz square wave, which drives the processor module's timer_50 / EVNT input.
- Implements the line-clock CSR at 177546 (address decode is external).
- Raises a vectored interrupt (vector 100) through the board's virq/istb/iack handshake.

Parameters:
- CLK_FREQ, 50000000, wb_clk_i frequency in Hz.
- TICK_HZ, 50, output tick rate in Hz. DIV = CLK_FREQ/TICK_HZ, integer, DIV >= 2 and even.
- VECTOR, 16'o000100, interrupt vector returned on ivec_o.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_cyc_i  in  1  bus cycle.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  2  byte select.
- wb_stb_i  in  1  CSR strobe (already qualified by the 177546 decode).
- wb_ack_o  out  1  bus acknowledge.
- virq_o  out  1  interrupt request.
- istb_i  in  1  vector-read strobe.
- iack_o  out  1  vector acknowledge.
- ivec_o  out  16  interrupt vector.
- timer50_o  out  1  50% duty square wave at TICK_HZ.
- tick_o  out  1  one-cycle pulse per period.

Behaviour:
- Reset (async, wb_rst_i=1): clears the prescaler, CSR bits 7/6, the interrupt pending flag and iack.
  - All outputs are 0 during and after reset.
  - ivec_o reads 0 unless iack_o is high.
- Prescaler: counter runs 0..DIV-1 and wraps to 0.
  - tick_o=1 for exactly the cycle where counter==DIV-1.
  - timer50_o is registered: 0 for counts 0..DIV/2-1, 1 for DIV/2..DIV-1.
  - First tick_o occurs DIV cycles after reset release.
- CSR bit 7 (MON): set by tick. Cleared by a low-byte write with dat[7]=0; writing 1 has no effect.
- CSR bit 6 (IE): read/write.
- All other CSR bits read 0 and ignore writes.
- Writes affect the CSR only when wb_sel_i[0]=1. A high-byte-only write is acknowledged with no effect.
- Same-cycle tick and a write clearing MON: MON ends up 1 (tick wins).
- Bus timing: wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - Ack is a one-cycle pulse, one cycle after the strobe; there is one ack per strobe assertion.
  - wb_dat_o = {8'h0, MON, IE, 6'b0}, valid while wb_ack_o=1; 0 otherwise.
  - The write takes effect on the ack edge.
- Interrupt FSM, states IDLE, PEND, ACK:
  - IDLE -> PEND on tick with IE=1 (the IE value before any same-cycle write).
  - PEND -> IDLE if IE is written 0 (request withdrawn).
  - PEND -> ACK when istb_i=1.
  - ACK -> IDLE when istb_i=0.
  - virq_o=1 only in PEND.
  - In ACK: iack_o=1 and ivec_o=VECTOR, both registered, first visible one cycle after istb_i rises.
  - A tick arriving in ACK or in the PEND->ACK cycle is latched. The FSM returns to PEND, not IDLE, when istb_i drops.
  - Multiple ticks while pending collapse into one request.
  - istb_i in IDLE is ignored: iack_o stays 0.
- Setting IE while MON=1 does not raise an interrupt; only a tick does.
- Reset mid-handshake: returns to IDLE immediately and drops iack_o/virq_o asynchronously.

Test Plan:
- Reset/prescaler (CLK_FREQ=100, TICK_HZ=10, so DIV=10): release reset -> tick_o high on cycles 10, 20, 30; timer50_o low 5 cycles, high 5 cycles.
- CSR access:
  - write 16'o000100, sel=2'b11 -> ack one cycle later, single pulse.
  - read -> 16'o000100.
  - after a tick, read -> 16'o000300.
  - write 16'o000100 -> MON cleared.
  - write with sel=2'b10 -> no change.
- Interrupt, IE=1: tick -> virq_o=1.
  - assert istb_i -> next cycle iack_o=1, ivec_o=16'o000100, virq_o=0.
  - drop istb_i -> iack_o=0, ivec_o=0.
- IE=0: ticks set MON but virq_o never rises.
  - Set IE while MON=1 -> still no virq_o until next tick.
  - With virq_o pending, write IE=0 -> virq_o drops next cycle.
- Collisions:
  - tick in the same cycle as a MON-clear write -> MON reads 1.
  - tick during ACK -> virq_o reasserts right after istb_i drops.
  - three ticks before istb_i -> exactly one acknowledge.
- Async reset asserted mid-ACK and mid-bus-cycle -> iack_o, virq_o, wb_ack_o go 0 without a clock edge; CSR reads 0 after release.

Source files
------------

// File: rtl/kw11l_timer.sv
// KW11-L compatible line clock: divides the bus clock into a TICK_HZ square wave,
// holds the line-clock CSR (MON/IE) and raises a vectored interrupt over virq/istb/iack.
module kw11l_timer #(
    parameter int          CLK_FREQ = 50000000,
    parameter int          TICK_HZ  = 50,
    parameter logic [15:0] VECTOR   = 16'o000100
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        virq_o,
    input  logic        istb_i,
    output logic        iack_o,
    output logic [15:0] ivec_o,
    output logic        timer50_o,
    output logic        tick_o,
    output logic [1:0]  irq_state_o
);

    localparam int             DIV  = CLK_FREQ / TICK_HZ;
    localparam int             CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF = CW'(DIV / 2);

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_PEND = 2'd1,
        IRQ_ACK  = 2'd2
    } irq_state_t;

    // Bus handshake: a request is wb_cyc_i & wb_stb_i; wb_ack_o answers it one cycle
    // later for exactly one cycle, and the write is committed on that same edge.
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          tick;
    logic          mon;
    logic          ie;
    logic          wr_en;
    logic          ie_clr;
    logic          tick_ie;
    logic          relatch;
    irq_state_t    state;
    logic          unused_bits;

    assign tick    = (cnt == LAST);
    assign cnt_nxt = tick ? '0 : cnt + CW'(1);
    assign tick_o  = tick;

    assign wr_en   = wb_cyc_i & wb_stb_i & wb_we_i & ~wb_ack_o & wb_sel_i[0];
    assign ie_clr  = wr_en & ~wb_dat_i[6];
    // The IE value sampled here is the one before any same-cycle write.
    assign tick_ie = tick & ie;

    assign wb_dat_o    = wb_ack_o ? {8'h00, mon, ie, 6'b000000} : 16'h0000;
    assign irq_state_o = state;
    assign unused_bits = ^{wb_dat_i[15:8], wb_dat_i[5:0], wb_sel_i[1]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt       <= '0;
            timer50_o <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            timer50_o <= (cnt_nxt >= HALF);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            mon      <= 1'b0;
            ie       <= 1'b0;
        end else begin
            wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
            // A tick beats a same-cycle write that tries to clear MON.
            if (tick)
                mon <= 1'b1;
            else if (wr_en && !wb_dat_i[7])
                mon <= 1'b0;
            if (wr_en)
                ie <= wb_dat_i[6];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IRQ_IDLE;
            virq_o  <= 1'b0;
            iack_o  <= 1'b0;
            ivec_o  <= 16'h0000;
            relatch <= 1'b0;
        end else begin
            case (state)
                IRQ_IDLE: begin
                    if (tick_ie) begin
                        state  <= IRQ_PEND;
                        virq_o <= 1'b1;
                    end
                end
                IRQ_PEND: begin
                    if (istb_i) begin
                        state   <= IRQ_ACK;
                        virq_o  <= 1'b0;
                        iack_o  <= 1'b1;
                        ivec_o  <= VECTOR;
                        relatch <= tick_ie;
                    end else if (ie_clr) begin
                        state  <= IRQ_IDLE;
                        virq_o <= 1'b0;
                    end
                end
                IRQ_ACK: begin
                    if (!istb_i) begin
                        iack_o  <= 1'b0;
                        ivec_o  <= 16'h0000;
                        relatch <= 1'b0;
                        // A tick seen during the vector read re-arms the request.
                        if (relatch || tick_ie) begin
                            state  <= IRQ_PEND;
                            virq_o <= 1'b1;
                        end else begin
                            state <= IRQ_IDLE;
                        end
                    end else if (tick_ie) begin
                        relatch <= 1'b1;
                    end else if (ie_clr) begin
                        relatch <= 1'b0;
                    end
                end
                default: begin
                    state   <= IRQ_IDLE;
                    virq_o  <= 1'b0;
                    iack_o  <= 1'b0;
                    ivec_o  <= 16'h0000;
                    relatch <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kw11l_timer.sv
// Directed bench for kw11l_timer with DIV=10; the bench's own edge counter predicts ticks.
module tb_kw11l_timer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [1:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        virq_o;
    logic        istb_i;
    logic        iack_o;
    logic [15:0] ivec_o;
    logic        timer50_o;
    logic        tick_o;
    logic [1:0]  irq_state_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [15:0] rd;

    kw11l_timer #(.CLK_FREQ(100), .TICK_HZ(10), .VECTOR(16'o000100)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_cyc_i    (wb_cyc_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_stb_i    (wb_stb_i),
        .wb_ack_o    (wb_ack_o),
        .virq_o      (virq_o),
        .istb_i      (istb_i),
        .iack_o      (iack_o),
        .ivec_o      (ivec_o),
        .timer50_o   (timer50_o),
        .tick_o      (tick_o),
        .irq_state_o (irq_state_o)
    );

    // clock / reset-relative edge counter
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        if (wb_rst_i) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_to(input int phase);
        while ((cyc % 10) != phase) @(negedge wb_clk_i);
    endtask

    task automatic bus_write(input logic [15:0] d, input logic [1:0] sel, input bit hold);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_dat_i = d; wb_sel_i = sel;
        #1 check("wr_ack_pre", wb_ack_o, 1'b0);
        @(negedge wb_clk_i);
        check("wr_ack", wb_ack_o, 1'b1);
        if (hold) begin
            @(negedge wb_clk_i);
            check("wr_ack_single", wb_ack_o, 1'b0);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 16'h0; wb_sel_i = 2'b00;
        @(negedge wb_clk_i);
        check("wr_ack_end", wb_ack_o, 1'b0);
    endtask

    task automatic bus_read(output logic [15:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 2'b11;
        @(negedge wb_clk_i);
        check("rd_ack", wb_ack_o, 1'b1);
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_sel_i = 2'b00;
        @(negedge wb_clk_i);
        check("rd_ack_end", wb_ack_o, 1'b0);
        check("rd_dat_idle", wb_dat_o, 16'h0);
    endtask

    initial begin
        wb_rst_i = 1'b1; wb_dat_i = 16'h0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = 2'b00; wb_stb_i = 1'b0; istb_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("rst_tick", tick_o, 1'b0);
        check("rst_t50", timer50_o, 1'b0);
        check("rst_virq", virq_o, 1'b0);
        check("rst_iack", iack_o, 1'b0);
        check("rst_ivec", ivec_o, 16'h0);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_dat", wb_dat_o, 16'h0);
        check("rst_state", irq_state_o, S_IDLE);
        wb_rst_i = 1'b0;

        // prescaler: tick on the 10th, 20th, 30th cycle; square wave 5 low / 5 high
        for (int n = 0; n < 30; n++) begin
            check("pre_tick", tick_o, ((n % 10) == 9) ? 1'b1 : 1'b0);
            check("pre_t50", timer50_o, ((n % 10) >= 5) ? 1'b1 : 1'b0);
            check("pre_virq", virq_o, 1'b0);
            @(negedge wb_clk_i);
        end

        // CSR write/read (MON was set by the ticks; this write clears it and sets IE)
        wait_to(1);
        bus_write(16'o000100, 2'b11, 1'b1);
        bus_read(rd);
        check("csr_ie", rd, 16'o000100);

        // tick with IE=1 raises the request
        wait_to(0);
        check("irq_virq", virq_o, 1'b1);
        check("irq_state_pend", irq_state_o, S_PEND);
        bus_read(rd);
        check("csr_mon_ie", rd, 16'o000300);
        istb_i = 1'b1;
        #1 check("iack_delay", iack_o, 1'b0);
        @(negedge wb_clk_i);
        check("iack_on", iack_o, 1'b1);
        check("ivec_on", ivec_o, 16'o000100);
        check("virq_in_ack", virq_o, 1'b0);
        check("state_ack", irq_state_o, S_ACK);
        @(negedge wb_clk_i);
        check("iack_hold", iack_o, 1'b1);
        istb_i = 1'b0;
        @(negedge wb_clk_i);
        check("iack_off", iack_o, 1'b0);
        check("ivec_off", ivec_o, 16'h0);
        check("virq_after", virq_o, 1'b0);
        check("state_idle", irq_state_o, S_IDLE);

        // clearing MON, then a high-byte-only write that must not land
        bus_write(16'o000100, 2'b11, 1'b0);
        bus_read(rd);
        check("mon_clear", rd, 16'o000100);
        wait_to(0);
        check("virq_2", virq_o, 1'b1);
        bus_write(16'o000000, 2'b10, 1'b0);
        bus_read(rd);
        check("sel_hi_only", rd, 16'o000300);
        check("virq_sel_hi", virq_o, 1'b1);

        // withdraw a pending request by clearing IE
        bus_write(16'o000000, 2'b11, 1'b0);
        check("virq_withdraw", virq_o, 1'b0);
        check("state_withdraw", irq_state_o, S_IDLE);

        // IE=0: ticks set MON, no request
        while (cyc < 72) begin
            check("ie0_virq", virq_o, 1'b0);
            @(negedge wb_clk_i);
        end
        bus_read(rd);
        check("ie0_mon", rd, 16'o000200);
        bus_write(16'o000300, 2'b11, 1'b0);
        while (cyc < 80) begin
            check("ie_set_no_irq", virq_o, 1'b0);
            @(negedge wb_clk_i);
        end
        check("ie_next_tick", virq_o, 1'b1);
        bus_read(rd);
        check("csr_mon_ie_2", rd, 16'o000300);

        // tick during ACK re-arms the request when istb drops
        istb_i = 1'b1;
        @(negedge wb_clk_i);
        check("ack2_iack", iack_o, 1'b1);
        while (cyc < 91) @(negedge wb_clk_i);
        check("ack2_hold_iack", iack_o, 1'b1);
        check("ack2_hold_virq", virq_o, 1'b0);
        istb_i = 1'b0;
        @(negedge wb_clk_i);
        check("relatch_virq", virq_o, 1'b1);
        check("relatch_iack", iack_o, 1'b0);
        check("relatch_ivec", ivec_o, 16'h0);
        check("relatch_state", irq_state_o, S_PEND);
        istb_i = 1'b1;
        @(negedge wb_clk_i);
        check("ack3_iack", iack_o, 1'b1);
        istb_i = 1'b0;
        @(negedge wb_clk_i);
        check("ack3_virq", virq_o, 1'b0);
        check("ack3_state", irq_state_o, S_IDLE);

        // three ticks collapse into one acknowledge
        wait_to(0);
        check("multi_virq", virq_o, 1'b1);
        while (cyc < 121) @(negedge wb_clk_i);
        check("multi_virq_held", virq_o, 1'b1);
        istb_i = 1'b1;
        @(negedge wb_clk_i);
        check("multi_iack", iack_o, 1'b1);
        istb_i = 1'b0;
        while (cyc < 129) begin
            @(negedge wb_clk_i);
            check("multi_once_virq", virq_o, 1'b0);
            check("multi_once_iack", iack_o, 1'b0);
        end

        // tick coincides with a MON-clearing write: MON stays set
        wait_to(9);
        bus_write(16'o000100, 2'b11, 1'b0);
        bus_read(rd);
        check("tick_beats_clear", rd, 16'o000300);
        check("tick_beats_virq", virq_o, 1'b1);

        // tick in the PEND->ACK cycle is kept
        wait_to(9);
        istb_i = 1'b1;
        @(negedge wb_clk_i);
        check("pa_iack", iack_o, 1'b1);
        check("pa_virq", virq_o, 1'b0);
        istb_i = 1'b0;
        @(negedge wb_clk_i);
        check("pa_relatch", virq_o, 1'b1);
        check("pa_state", irq_state_o, S_PEND);

        // async reset in the middle of ACK and a bus cycle
        istb_i = 1'b1;
        @(negedge wb_clk_i);
        check("ar_state", irq_state_o, S_ACK);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 2'b11;
        @(negedge wb_clk_i);
        check("ar_pre_ack", wb_ack_o, 1'b1);
        check("ar_pre_iack", iack_o, 1'b1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("ar_iack", iack_o, 1'b0);
        check("ar_virq", virq_o, 1'b0);
        check("ar_ack", wb_ack_o, 1'b0);
        check("ar_dat", wb_dat_o, 16'h0);
        check("ar_ivec", ivec_o, 16'h0);
        check("ar_state_idle", irq_state_o, S_IDLE);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_sel_i = 2'b00; istb_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        bus_read(rd);
        check("ar_csr", rd, 16'h0);

        // istb in IDLE is ignored
        istb_i = 1'b1;
        repeat (2) begin
            @(negedge wb_clk_i);
            check("idle_istb_iack", iack_o, 1'b0);
            check("idle_istb_ivec", ivec_o, 16'h0);
        end
        istb_i = 1'b0;
        while (cyc < 9) @(negedge wb_clk_i);
        check("post_rst_tick", tick_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
